// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result-source select encoding,
// load funct3 codes and a legality helper for load sizes.
package wb_pkg;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_LINK = 2'b10,
    SEL_IMM  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // 111 is never a load; LD and LWU only exist on a 64-bit datapath.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_rv64);
    logic ok;
    ok = (f3 != 3'b111);
    if (!is_rv64 && (f3 == F3_LD || f3 == F3_LWU)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: shifts the raw memory word down to the addressed
// byte, sign/zero-extends to XLEN and flags misaligned or reserved loads.
// Flagged loads always produce zero data.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN/32:0] addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misalign,
  output logic            illegal
);

  logic [XLEN-1:0] shifted;

  // Shift, extend by load size and detect alignment/legality problems.
  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    data     = '0;
    misalign = 1'b0;
    illegal  = !f3_legal(funct3, XLEN == 64);
    case (funct3)
      F3_LB:  data = XLEN'($signed(shifted[7:0]));
      F3_LH:  begin
        misalign = addr_lo[0];
        data     = XLEN'($signed(shifted[15:0]));
      end
      F3_LW:  begin
        misalign = |addr_lo[1:0];
        data     = XLEN'($signed(shifted[31:0]));
      end
      F3_LD:  begin
        misalign = |addr_lo;
        data     = shifted;
      end
      F3_LBU: data = XLEN'(shifted[7:0]);
      F3_LHU: begin
        misalign = addr_lo[0];
        data     = XLEN'(shifted[15:0]);
      end
      F3_LWU: begin
        misalign = |addr_lo[1:0];
        data     = XLEN'(shifted[31:0]);
      end
      default: data = '0;
    endcase
    if (illegal) misalign = 1'b0;
    if (misalign || illegal) data = '0;
  end

endmodule

// File: rtl/wb_stage.sv
// Registered RISC-V writeback stage. Selects ALU / load / link / immediate
// result, registers it with its per-entry fault flags and drives the
// register-file write port through a valid/ready handshake.
// Build option WB_SKID_EN: adds a second (skid) entry so in_ready comes
// straight from a flop instead of combinationally from out_ready.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4,
  parameter int RF_AW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN/32:0] in_addr_lo,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [RF_AW-1:0] in_rd,
  input  logic             in_we,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             ld_misalign,
  output logic             ld_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [RF_AW-1:0] rd;
    logic             we;
    logic             misalign;
    logic             illegal;
  } wb_entry_t;

  logic [XLEN-1:0] ld_data;
  logic            ld_mis;
  logic            ld_ill;
  wb_entry_t       new_entry;
  wb_entry_t       out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            accept;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .funct3   (in_funct3),
    .addr_lo  (in_addr_lo),
    .rdata    (mem_rdata),
    .data     (ld_data),
    .misalign (ld_mis),
    .illegal  (ld_ill)
  );

  // Build the incoming entry from the selected result source; load flags only count for MEM.
  always_comb begin
    new_entry    = '0;
    new_entry.rd = in_rd;
    new_entry.we = in_we;
    case (wb_sel_e'(in_sel))
      SEL_ALU:  new_entry.data = alu_result;
      SEL_MEM:  begin
        new_entry.data     = ld_data;
        new_entry.misalign = ld_mis;
        new_entry.illegal  = ld_ill;
      end
      SEL_LINK: new_entry.data = pc + XLEN'(PC_INC);
      SEL_IMM:  new_entry.data = imm;
      default:  new_entry.data = '0;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef WB_SKID_EN
  wb_entry_t skid_q, skid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  // Output slot refills from skid first (oldest), else from input; a stalled accept parks in skid.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // Skid entry and registered ready; reset empties everything and reopens the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  // Single output register: load on accept, clear when the entry retires with nothing behind it.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = new_entry;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_d       = '0;
      out_valid_d = 1'b0;
    end
  end
`endif

  // Output register; reset discards the held entry so no write can be signalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign rf_waddr    = out_q.rd;
  assign rf_wdata    = out_q.data;
  assign ld_misalign = out_q.misalign;
  assign ld_illegal  = out_q.illegal;
  assign rf_we       = out_valid_q && out_ready && out_q.we && (out_q.rd != '0)
                       && !out_q.misalign && !out_q.illegal;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (XLEN=32, PC_INC=4, RF_AW=5): directed
// vector table, stall/ordering and async-reset sequences, then randomized
// traffic scored against a behavioural model. Handles WB_SKID_EN builds.
module tb_wb_stage;

`ifdef WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        out_ready;
  logic        out_valid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ld_misalign;
  logic        ld_illegal;

  int checks = 0;
  int errors = 0;

  wb_stage #(.XLEN(32), .PC_INC(4), .RF_AW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_funct3   (in_funct3),
    .in_addr_lo  (in_addr_lo),
    .alu_result  (alu_result),
    .mem_rdata   (mem_rdata),
    .pc          (pc),
    .imm         (imm),
    .in_rd       (in_rd),
    .in_we       (in_we),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .ld_misalign (ld_misalign),
    .ld_illegal  (ld_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] val;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_mis;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic        ill;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Put val on the selected source and distinct filler on the others.
  task automatic applyStimulus(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                               input logic [31:0] val, input logic [4:0] rd, input logic we);
    in_sel     = sel;
    in_funct3  = f3;
    in_addr_lo = off;
    alu_result = (sel == 2'd0) ? val : 32'hDEAD_0A1F;
    mem_rdata  = (sel == 2'd1) ? val : 32'hDEAD_0B2E;
    pc         = (sel == 2'd2) ? val : 32'hDEAD_0C3D;
    imm        = (sel == 2'd3) ? val : 32'hDEAD_0D4C;
    in_rd      = rd;
    in_we      = we;
  endtask

  // Behavioural model from the load/select rules using plain arithmetic.
  function automatic exp_t refModel(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                                    input logic [31:0] alu, input logic [31:0] mem,
                                    input logic [31:0] pcv, input logic [31:0] immv,
                                    input logic [4:0] rd, input logic we);
    exp_t e;
    longint unsigned v;
    int size;
    bit sgn;
    e.data = 32'd0; e.mis = 1'b0; e.ill = 1'b0; e.rd = rd; e.we = we;
    case (sel)
      2'd0: e.data = alu;
      2'd2: begin
        v = (64'(pcv) + 64'd4) % (64'd1 << 32);
        e.data = v[31:0];
      end
      2'd3: e.data = immv;
      default: begin
        size = 1 << f3[1:0];
        sgn  = (f3[2] == 1'b0);
        if (f3 == 3'd7 || size == 8 || (size == 4 && !sgn)) e.ill = 1'b1;
        else if ((int'(off) % size) != 0) e.mis = 1'b1;
        else begin
          v = (64'(mem) >> (8 * int'(off))) % (64'd1 << (8 * size));
          if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
          e.data = v[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // One scoreboard cycle: inputs already driven, sample mid-cycle, then advance.
  task automatic scoreCycle();
    exp_t e;
    #2;
    checkOutput("valid_vs_model", out_valid, sb.size() != 0);
`ifdef WB_SKID_EN
    checkOutput("in_ready_rand", in_ready, sb.size() < 2);
`else
    checkOutput("in_ready_rand", in_ready, (sb.size() == 0) || out_ready);
`endif
    if (out_valid && sb.size() != 0) begin
      e = sb[0];
      checkOutput("rand_wdata", rf_wdata, e.data);
      checkOutput("rand_waddr", rf_waddr, e.rd);
      checkOutput("rand_mis", ld_misalign, e.mis);
      checkOutput("rand_ill", ld_illegal, e.ill);
      checkOutput("rand_rf_we", rf_we, out_ready && e.we && e.rd != 0 && !e.mis && !e.ill);
      if (out_ready) void'(sb.pop_front());
    end
    if (in_valid && in_ready)
      sb.push_back(refModel(in_sel, in_funct3, in_addr_lo, alu_result, mem_rdata, pc, imm, in_rd, in_we));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] seq_val[3];
    logic [31:0] retired[$];
    int sent;

    vecs[0]  = '{"alu",        2'd0, 3'd0, 2'd0, 32'h1234_5678, 5'd5,  1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{"lb",         2'd1, 3'd0, 2'd3, 32'h80FF_0000, 5'd6,  1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"lbu",        2'd1, 3'd4, 2'd3, 32'h80FF_0000, 5'd6,  1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{"lh",         2'd1, 3'd1, 2'd2, 32'h80FF_0000, 5'd7,  1'b1, 32'hFFFF_80FF, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"lhu",        2'd1, 3'd5, 2'd2, 32'h80FF_0000, 5'd7,  1'b1, 32'h0000_80FF, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{"lw",         2'd1, 3'd2, 2'd0, 32'h80FF_0000, 5'd8,  1'b1, 32'h80FF_0000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"lh_mis",     2'd1, 3'd1, 2'd1, 32'h80FF_0000, 5'd8,  1'b1, 32'h0,         1'b0, 1'b1, 1'b0};
    vecs[7]  = '{"lw_mis",     2'd1, 3'd2, 2'd2, 32'h80FF_0000, 5'd8,  1'b1, 32'h0,         1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"f3_111",     2'd1, 3'd7, 2'd0, 32'h80FF_0000, 5'd9,  1'b1, 32'h0,         1'b0, 1'b0, 1'b1};
    vecs[9]  = '{"ld_rv32",    2'd1, 3'd3, 2'd0, 32'h80FF_0000, 5'd9,  1'b1, 32'h0,         1'b0, 1'b0, 1'b1};
    vecs[10] = '{"lwu_rv32",   2'd1, 3'd6, 2'd0, 32'h80FF_0000, 5'd9,  1'b1, 32'h0,         1'b0, 1'b0, 1'b1};
    vecs[11] = '{"link_wrap",  2'd2, 3'd0, 2'd0, 32'hFFFF_FFFC, 5'd1,  1'b1, 32'h0,         1'b1, 1'b0, 1'b0};
    vecs[12] = '{"link",       2'd2, 3'd0, 2'd0, 32'h0000_0100, 5'd1,  1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{"imm",        2'd3, 3'd0, 2'd0, 32'hABCD_E000, 5'd31, 1'b1, 32'hABCD_E000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{"rd_x0",      2'd0, 3'd0, 2'd0, 32'h0000_0055, 5'd0,  1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{"we_off",     2'd0, 3'd0, 2'd0, 32'h0000_0066, 5'd7,  1'b0, 32'h0000_0066, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{"alu_f3_111", 2'd0, 3'd7, 2'd1, 32'h0000_0077, 5'd3,  1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{"lb_pos",     2'd1, 3'd0, 2'd0, 32'h0000_007F, 5'd4,  1'b1, 32'h0000_007F, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    applyStimulus(2'd0, 3'd0, 2'd0, 32'd0, 5'd0, 1'b0);
    #12;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_rf_we", rf_we, 1'b0);
    checkOutput("rst_waddr", rf_waddr, 5'd0);
    checkOutput("rst_wdata", rf_wdata, 32'd0);
    checkOutput("rst_mis", ld_misalign, 1'b0);
    checkOutput("rst_ill", ld_illegal, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, one entry per cycle with the register file always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].f3, vecs[i].off, vecs[i].val, vecs[i].rd, vecs[i].we);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput({vecs[i].name, "_valid"}, out_valid, 1'b1);
      checkOutput({vecs[i].name, "_wdata"}, rf_wdata, vecs[i].exp_data);
      checkOutput({vecs[i].name, "_waddr"}, rf_waddr, vecs[i].rd);
      checkOutput({vecs[i].name, "_rf_we"}, rf_we, vecs[i].exp_we);
      checkOutput({vecs[i].name, "_mis"}, ld_misalign, vecs[i].exp_mis);
      checkOutput({vecs[i].name, "_ill"}, ld_illegal, vecs[i].exp_ill);
    end
    @(posedge clk); #1;
    checkOutput("drain_valid", out_valid, 1'b0);
    checkOutput("drain_flags", {ld_misalign, ld_illegal}, 2'b00);

    // Stall three cycles over back-to-back A,B,C and check hold, ready and order.
    seq_val[0] = 32'hA0A0_0001; seq_val[1] = 32'hB0B0_0002; seq_val[2] = 32'hC0C0_0003;
    sent = 0;
    for (int k = 0; k < 20 && retired.size() < 3; k++) begin
      out_ready = (k >= 4);
      in_valid  = (sent < 3);
      applyStimulus(2'd0, 3'd0, 2'd0, seq_val[sent < 3 ? sent : 2], 5'(10 + sent), 1'b1);
      #2;
      if (k >= 1 && k <= 3) begin
        checkOutput("stall_hold_A", rf_wdata, seq_val[0]);
        checkOutput("stall_valid", out_valid, 1'b1);
        checkOutput("stall_rf_we", rf_we, 1'b0);
        checkOutput("stall_in_ready", in_ready, (k == 1) ? SKID : 1'b0);
      end
      if (out_valid && out_ready) retired.push_back(rf_wdata);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("order_count", retired.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput("order_value", (i < retired.size()) ? retired[i] : 32'hFFFF_FFFF, seq_val[i]);

    // Async reset while a flagged entry is stalled on the output.
    out_ready = 1'b0;
    applyStimulus(2'd1, 3'd7, 2'd0, 32'h1111_2222, 5'd9, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("pre_rst_valid", out_valid, 1'b1);
    checkOutput("pre_rst_ill", ld_illegal, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", out_valid, 1'b0);
    checkOutput("async_waddr", rf_waddr, 5'd0);
    checkOutput("async_ill", ld_illegal, 1'b0);
    checkOutput("async_rf_we", rf_we, 1'b0);
    checkOutput("async_in_ready", in_ready, 1'b1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_valid", out_valid, 1'b0);
    checkOutput("post_rst_in_ready", in_ready, 1'b1);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      alu_result = $urandom; mem_rdata = $urandom; pc = $urandom; imm = $urandom;
      if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFFC;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      scoreCycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) scoreCycle();
    checkOutput("final_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
